// File: rtl/hazard_pkg.sv
// Shared types, encodings and opcode decode for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned RegIdxW = 4;
  localparam int unsigned OpW     = 4;

  localparam logic [OpW-1:0] OP_ADD    = 4'b1100;
  localparam logic [OpW-1:0] OP_LW     = 4'b0100;
  localparam logic [OpW-1:0] OP_SW     = 4'b0011;
  localparam logic [OpW-1:0] OP_BRANCH = 4'b0010;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  typedef struct packed {
    logic               valid_wr;
    logic [RegIdxW-1:0] dest;
    logic               is_load;
  } slot_t;

  // Every opcode with bit 3 set is an ALU op (ADD included).
  function automatic logic writes_reg(input logic [OpW-1:0] op);
    return op[3] | (op == OP_LW);
  endfunction

  function automatic logic is_load(input logic [OpW-1:0] op);
    return op == OP_LW;
  endfunction

  function automatic logic uses_a(input logic [OpW-1:0] op);
    return op[3] | (op == OP_LW) | (op == OP_SW) | (op == OP_BRANCH);
  endfunction

  function automatic logic uses_b(input logic [OpW-1:0] op);
    return op[3] | (op == OP_SW) | (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_slot_pipe.sv
// Three-deep EX/MEM/WB destination tracking pipe; a bubble replaces the EX entry.
module hazard_slot_pipe
  import hazard_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_bubble,
  input  slot_t i_id_slot,
  output slot_t o_ex_slot,
  output slot_t o_mem_slot,
  output slot_t o_wb_slot
);

  slot_t r_ex;
  slot_t r_mem;
  slot_t r_wb;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= i_bubble ? '0 : i_id_slot;
    end
  end

  assign o_ex_slot  = r_ex;
  assign o_mem_slot = r_mem;
  assign o_wb_slot  = r_wb;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding select, load-use stall and branch flush control for the EX stage.
// Define HAZARD_FWD_EX_FWD_EN to forward MEM-stage ALU results (select 01).
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter int unsigned OPCODE_WIDTH        = 4,
  parameter int unsigned BRANCH_PENALTY      = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_id_valid,
  input  logic [OPCODE_WIDTH-1:0]        i_id_opcode,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] i_id_src_a,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] i_id_src_b,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] i_id_dest,
  input  logic                           i_ex_branch_taken,
  output logic                           o_stall,
  output logic                           o_flush,
  output logic [1:0]                     o_fwd_sel_a,
  output logic [1:0]                     o_fwd_sel_b
);

  localparam logic [2:0] CntLoad = 3'(BRANCH_PENALTY - 1);

  state_e     r_state;
  logic [2:0] r_cnt;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  slot_t w_id_slot;
  slot_t w_ex_slot;
  slot_t w_mem_slot;
  logic  w_uses_a, w_uses_b;
  logic  w_ex_a, w_ex_b, w_mem_a, w_mem_b;
  logic  w_hazard, w_flush, w_stall, w_bubble;
  logic [1:0] w_sel_a, w_sel_b;

  always_comb begin
    w_id_slot.valid_wr = i_id_valid & writes_reg(i_id_opcode);
    w_id_slot.dest     = i_id_dest;
    w_id_slot.is_load  = i_id_valid & is_load(i_id_opcode);
  end

  hazard_slot_pipe u_slot_pipe (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_bubble   (w_bubble),
    .i_id_slot  (w_id_slot),
    .o_ex_slot  (w_ex_slot),
    .o_mem_slot (w_mem_slot),
    .o_wb_slot  ()
  );

  assign w_uses_a = i_id_valid & uses_a(i_id_opcode);
  assign w_uses_b = i_id_valid & uses_b(i_id_opcode);
  assign w_ex_a   = w_uses_a & w_ex_slot.valid_wr & (w_ex_slot.dest == i_id_src_a);
  assign w_ex_b   = w_uses_b & w_ex_slot.valid_wr & (w_ex_slot.dest == i_id_src_b);
  assign w_mem_a  = w_uses_a & w_mem_slot.valid_wr & (w_mem_slot.dest == i_id_src_a);
  assign w_mem_b  = w_uses_b & w_mem_slot.valid_wr & (w_mem_slot.dest == i_id_src_b);

`ifdef HAZARD_FWD_EX_FWD_EN
  assign w_hazard = (w_ex_a | w_ex_b) & w_ex_slot.is_load;
  assign w_sel_a  = w_ex_a ? FWD_MEM : (w_mem_a ? FWD_WB : FWD_REGFILE);
  assign w_sel_b  = w_ex_b ? FWD_MEM : (w_mem_b ? FWD_WB : FWD_REGFILE);
`else
  // Without EX forwarding any EX-slot producer must drain one stage first.
  assign w_hazard = w_ex_a | w_ex_b;
  assign w_sel_a  = w_mem_a ? FWD_WB : FWD_REGFILE;
  assign w_sel_b  = w_mem_b ? FWD_WB : FWD_REGFILE;
`endif

  assign w_flush  = i_ex_branch_taken | (r_state == StFlush);
  assign w_stall  = w_hazard & ~w_flush;
  assign w_bubble = w_stall | w_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StRun;
      r_cnt   <= '0;
      r_fwd_a <= FWD_REGFILE;
      r_fwd_b <= FWD_REGFILE;
    end else begin
      r_fwd_a <= w_bubble ? FWD_REGFILE : w_sel_a;
      r_fwd_b <= w_bubble ? FWD_REGFILE : w_sel_b;
      if (i_ex_branch_taken) begin
        // The taken cycle itself is the first flush cycle.
        if (BRANCH_PENALTY > 1) begin
          r_state <= StFlush;
          r_cnt   <= CntLoad;
        end else begin
          r_state <= StRun;
          r_cnt   <= '0;
        end
      end else begin
        unique case (r_state)
          StFlush: begin
            if (r_cnt <= 3'd1) begin
              r_state <= StRun;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - 3'd1;
            end
          end
          StStall: r_state <= StRun;
          default: if (w_stall) r_state <= StStall;
        endcase
      end
    end
  end

  assign o_stall     = w_stall;
  assign o_flush     = w_flush;
  assign o_fwd_sel_a = r_fwd_a;
  assign o_fwd_sel_b = r_fwd_b;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against an instruction-history model.
module tb_hazard_fwd_ctrl;

  localparam int unsigned Bp = 2;
`ifdef HAZARD_FWD_EX_FWD_EN
  localparam bit ExFwd = 1'b1;
`else
  localparam bit ExFwd = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_id_valid = 1'b0, i_br = 1'b0;
  logic [3:0] i_op = '0, i_a = '0, i_b = '0, i_d = '0;
  logic       o_stall, o_flush;
  logic [1:0] o_sel_a, o_sel_b;

  int total = 0;
  int bad   = 0;

  // Model: what sits in EX/MEM/WB (index 0 = EX), flush cycles left, registered selects.
  bit       hw[3];
  bit [3:0] hd[3];
  bit       hl[3];
  int       flush_left = 0;
  bit [1:0] m_sel_a = 0, m_sel_b = 0;
  bit       m_stall_last = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(
    .REG_INDEX_BIT_WIDTH (4),
    .OPCODE_WIDTH        (4),
    .BRANCH_PENALTY      (Bp)
  ) dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_id_valid        (i_id_valid),
    .i_id_opcode       (i_op),
    .i_id_src_a        (i_a),
    .i_id_src_b        (i_b),
    .i_id_dest         (i_d),
    .i_ex_branch_taken (i_br),
    .o_stall           (o_stall),
    .o_flush           (o_flush),
    .o_fwd_sel_a       (o_sel_a),
    .o_fwd_sel_b       (o_sel_b)
  );

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Instruction classes straight from the opcode table.
  task automatic classify(input logic [3:0] op, output bit wr, output bit ld,
                          output bit ra, output bit rb);
    wr = 0; ld = 0; ra = 0; rb = 0;
    if (op[3]) begin wr = 1; ra = 1; rb = 1; end
    else if (op == 4'b0100) begin wr = 1; ld = 1; ra = 1; end
    else if (op == 4'b0011 || op == 4'b0010) begin ra = 1; rb = 1; end
  endtask

  task automatic cycle(input bit rst, input bit v, input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] d, input bit br);
    bit wr, ld, ra, rb, ex_a, ex_b, mem_a, mem_b, e_flush, e_stall;
    @(posedge clk);
    #1;
    i_rst = rst; i_id_valid = v; i_op = op; i_a = a; i_b = b; i_d = d; i_br = br;
    @(negedge clk);
    classify(op, wr, ld, ra, rb);
    ra &= v; rb &= v; wr &= v; ld &= v;
    ex_a  = ra && hw[0] && hd[0] == a;
    ex_b  = rb && hw[0] && hd[0] == b;
    mem_a = ra && hw[1] && hd[1] == a;
    mem_b = rb && hw[1] && hd[1] == b;
    e_flush = br || flush_left > 0;
    e_stall = !e_flush && (ex_a || ex_b) && (hl[0] || !ExFwd);
    chk("stall", {1'b0, o_stall}, {1'b0, e_stall});
    chk("flush", {1'b0, o_flush}, {1'b0, e_flush});
    chk("sel_a", o_sel_a, m_sel_a);
    chk("sel_b", o_sel_b, m_sel_b);
    m_stall_last = e_stall;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin hw[k] = 0; hd[k] = 0; hl[k] = 0; end
      flush_left = 0; m_sel_a = 0; m_sel_b = 0; m_stall_last = 0;
    end else begin
      if (e_flush || e_stall) begin
        m_sel_a = 0; m_sel_b = 0;
      end else begin
        m_sel_a = (ex_a && ExFwd) ? 2'b01 : (mem_a ? 2'b10 : 2'b00);
        m_sel_b = (ex_b && ExFwd) ? 2'b01 : (mem_b ? 2'b10 : 2'b00);
      end
      for (int k = 2; k > 0; k--) begin hw[k] = hw[k-1]; hd[k] = hd[k-1]; hl[k] = hl[k-1]; end
      hw[0] = wr && !e_flush && !e_stall;
      hd[0] = d;
      hl[0] = ld && !e_flush && !e_stall;
      if (br) flush_left = Bp - 1;
      else if (flush_left > 0) flush_left--;
    end
  endtask

  // Present an instruction and hold it in ID while the model says it stalls.
  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d);
    cycle(0, 1, op, a, b, d, 0);
    for (int n = 0; n < 3 && m_stall_last; n++) cycle(0, 1, op, a, b, d, 0);
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin hw[k] = 0; hd[k] = 0; hl[k] = 0; end
    repeat (2) @(posedge clk);
    nop(1);
    // Back-to-back ALU dependency.
    issue(4'b1100, 4'd0, 4'd1, 4'd2);
    issue(4'b1100, 4'd2, 4'd2, 4'd3);
    nop(3);
    // Load-use into a store.
    issue(4'b0100, 4'd1, 4'd0, 4'd5);
    issue(4'b0011, 4'd5, 4'd6, 4'd0);
    nop(3);
    // Producer two ahead, separated by a non-writer.
    issue(4'b1100, 4'd1, 4'd1, 4'd4);
    issue(4'b0011, 4'd1, 4'd2, 4'd0);
    issue(4'b1100, 4'd4, 4'd0, 4'd8);
    nop(3);
    // Taken branch beats a pending load-use; squashed IDs leave no slots.
    issue(4'b0100, 4'd2, 4'd0, 4'd9);
    cycle(0, 1, 4'b1100, 4'd9, 4'd9, 4'd10, 1);
    cycle(0, 1, 4'b1100, 4'd9, 4'd9, 4'd10, 0);
    issue(4'b1100, 4'd10, 4'd9, 4'd11);
    nop(3);
    // Two writers of r7: youngest wins.
    issue(4'b1100, 4'd1, 4'd2, 4'd7);
    issue(4'b1101, 4'd3, 4'd4, 4'd7);
    issue(4'b1100, 4'd7, 4'd7, 4'd1);
    nop(2);
    // Reset while flushing, then a reader of a just-written register.
    issue(4'b1100, 4'd1, 4'd2, 4'd12);
    cycle(0, 1, 4'b1100, 4'd12, 4'd0, 4'd13, 1);
    cycle(1, 1, 4'b1100, 4'd12, 4'd0, 4'd13, 0);
    issue(4'b1100, 4'd12, 4'd13, 4'd14);
    nop(2);
    // Random traffic over a small register range to provoke hazards.
    for (int t = 0; t < 400; t++) begin
      if (m_stall_last) begin
        cycle(0, i_id_valid, i_op, i_a, i_b, i_d, 0);
      end else begin
        cycle(($urandom_range(63) == 0), ($urandom_range(7) != 0), 4'($urandom_range(15)),
              4'($urandom_range(5)), 4'($urandom_range(5)), 4'($urandom_range(5)),
              ($urandom_range(9) == 0));
      end
    end
    nop(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
